// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
//
// Sits between the EX/MEM latch and the register-file write port. Loads and
// stores move over a byte-wide RAM bus one byte per cycle, little-endian,
// while stall_req holds the upstream pipeline. Non-memory instructions pass
// their ALU result straight to the registered write-back triple in one cycle.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   rdy                  global enable; 0 freezes every register
//   in_valid             upstream presents an instruction
//   in_is_load/store     memory operation kind (load wins if both set)
//   in_funct3            RV32I funct3: access size and sign handling
//   in_addr              ALU result: byte address, or write-back data
//   in_store_data        rs2 value for stores
//   in_rd, in_rd_we      destination register and its write enable
//   stall_req            combinational; upstream holds its inputs while high
//   mem_a, mem_wr        registered RAM byte address and write strobe
//   mem_dout             registered RAM write byte
//   mem_din              RAM read byte, valid the cycle after its address
//   wb_we/wb_addr/wb_data registered register-file write port

module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_we,
  output logic              stall_req,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [31:0]       wb_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  cnt;        // cycles spent in LOAD/STORE so far
  logic [1:0]  last;       // index of the final byte: N-1
  logic [2:0]  ld_f3;
  logic [4:0]  ld_rd;
  logic        ld_rd_we;
  logic [31:0] ld_buf;     // bytes received so far, little-endian lanes
  logic [23:0] st_bytes;   // store bytes still to be sent, next one in [7:0]

  logic        final_cyc;
  logic [1:0]  rcv_lane;
  logic [31:0] ld_word;

  // funct3[1:0]: 00 -> 1 byte, 01 -> 2 bytes, 1x -> 4 bytes.
  function automatic logic [1:0] last_byte(input logic [2:0] f3);
    if (f3[1])      return 2'd3;
    else if (f3[0]) return 2'd1;
    else            return 2'd0;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // In LOAD the read data lags the issued address by one cycle, so the byte
  // arriving while cnt = k belongs to lane k-1. The last byte arrives when
  // cnt = N, which is also the completing cycle.
  assign rcv_lane = cnt[1:0] - 2'd1;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no
    // latch is inferred on paths that do not assign it.
    final_cyc = 1'b0;
    stall_req = 1'b0;
    ld_word   = ld_buf;
    ld_word[{rcv_lane, 3'b000} +: 8] = mem_din;
    case (state)
      IDLE:    stall_req = in_valid & (in_is_load | in_is_store);
      LOAD: begin
        final_cyc = (cnt == ({1'b0, last} + 3'd1));
        stall_req = ~final_cyc;
      end
      STORE: begin
        final_cyc = (cnt == {1'b0, last});
        stall_req = ~final_cyc;
      end
      default: stall_req = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= '0;
      ld_f3    <= '0;
      ld_rd    <= '0;
      ld_rd_we <= 1'b0;
      ld_buf   <= '0;
      st_bytes <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          cnt    <= '0;
          if (in_valid && in_is_load) begin
            wb_we    <= 1'b0;
            mem_a    <= ADDR_W'(in_addr);
            last     <= last_byte(in_funct3);
            ld_f3    <= in_funct3;
            ld_rd    <= in_rd;
            ld_rd_we <= in_rd_we;
            state    <= LOAD;
          end else if (in_valid && in_is_store) begin
            wb_we    <= 1'b0;
            mem_a    <= ADDR_W'(in_addr);
            mem_wr   <= 1'b1;
            mem_dout <= in_store_data[7:0];
            st_bytes <= in_store_data[31:8];
            last     <= last_byte(in_funct3);
            state    <= STORE;
          end else if (in_valid) begin
            wb_we   <= in_rd_we;
            wb_addr <= in_rd;
            wb_data <= in_addr;
          end else begin
            wb_we <= 1'b0;
          end
        end

        LOAD: begin
          wb_we <= 1'b0;
          // Issue side runs one cycle ahead of the receive side.
          if (cnt < {1'b0, last}) mem_a <= mem_a + ADDR_W'(1);
          if (cnt != 3'd0)        ld_buf <= ld_word;
          if (final_cyc) begin
            wb_we   <= ld_rd_we;
            wb_addr <= ld_rd;
            wb_data <= extend(ld_word, ld_f3);
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        STORE: begin
          wb_we <= 1'b0;
          if (final_cyc) begin
            mem_wr <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            mem_a    <= mem_a + ADDR_W'(1);
            mem_dout <= st_bytes[7:0];
            st_bytes <= st_bytes >> 8;
            cnt      <= cnt + 3'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
//
// Ops are described as transactions. For each op the bench derives, from the
// stage's timing rules, what every output must be in each cycle relative to
// the op's issue cycle, and records those expectations in per-cycle tables.
// Load results come from a byte-array picture of RAM that the bench updates
// itself for every store it issues. A separate bus RAM answers the DUT.

module tb_mem_stage;

  localparam int ADDR_W = 32;
  localparam int MAXC   = 4096;
  localparam int RAM_SZ = 4096;   // RAM aliases on address bits [11:0]

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              in_valid;
  logic              in_is_load;
  logic              in_is_store;
  logic [2:0]        in_funct3;
  logic [31:0]       in_addr;
  logic [31:0]       in_store_data;
  logic [4:0]        in_rd;
  logic              in_rd_we;
  logic              stall_req;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .in_valid      (in_valid),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .in_rd_we      (in_rd_we),
    .stall_req     (stall_req),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .mem_dout      (mem_dout),
    .mem_din       (mem_din),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 29) + 7);
  endfunction

  // Bus RAM: synchronous read, data one cycle after the address. It shares
  // the global enable, so a frozen pipeline also sees a frozen read port.
  logic [7:0] bus_ram [RAM_SZ];
  bit         ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < RAM_SZ; i++) bus_ram[i] <= init_byte(i);
      ram_ready <= 1'b1;
    end else if (rdy) begin
      if (mem_wr) bus_ram[mem_a[11:0]] <= mem_dout;
      mem_din <= bus_ram[mem_a[11:0]];
    end
  end

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic        valid;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rd_we;
  } op_t;

  logic [7:0] gold_ram [RAM_SZ];

  bit          exp_stall [MAXC];
  bit          exp_wr    [MAXC];
  bit          chk_a     [MAXC];
  logic [31:0] exp_a     [MAXC];
  logic [7:0]  exp_dout  [MAXC];
  bit          exp_we    [MAXC];
  logic [4:0]  exp_wa    [MAXC];
  logic [31:0] exp_wd    [MAXC];
  logic [31:0] wb_log [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cur_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", tag, cur_cyc, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1])      return 4;
    else if (f3[0]) return 2;
    else            return 1;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [31:0] ai;
    w = '0;
    for (int i = 0; i < nbytes(f3); i++) begin
      ai = a + 32'(i);
      w[8*i +: 8] = gold_ram[ai[11:0]];
    end
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic op_t mk_op(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [4:0] rd, input logic we);
    op_t o;
    o.valid = 1'b1; o.ld = ld; o.st = st; o.f3 = f3;
    o.addr = a; o.sdata = d; o.rd = rd; o.rd_we = we;
    return o;
  endfunction

  function automatic op_t bubble_op();
    op_t o;
    o.valid = 1'b0;
    o.ld    = 1'($urandom_range(0, 1));
    o.st    = 1'($urandom_range(0, 1));
    o.f3    = 3'($urandom_range(0, 7));
    o.addr  = $urandom;
    o.sdata = $urandom;
    o.rd    = 5'($urandom_range(0, 31));
    o.rd_we = 1'($urandom_range(0, 1));
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  kind;
    int  where;
    o = bubble_op();
    o.valid = 1'b1;
    kind  = $urandom_range(0, 9);
    where = $urandom_range(0, 3);
    if (where == 0)      o.addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 31));
    else if (where == 1) o.addr = $urandom;
    else                 o.addr = 32'h0000_1000 + 32'($urandom_range(0, 47));
    case (kind)
      0, 1:    o.valid = 1'b0;
      4, 5, 6: begin o.ld = 1'b1; o.st = 1'b0; end
      7, 8:    begin o.ld = 1'b0; o.st = 1'b1; end
      9:       begin o.ld = 1'b1; o.st = 1'b1; end
      default: begin o.ld = 1'b0; o.st = 1'b0; o.addr = $urandom; end
    endcase
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    in_valid      = o.valid;
    in_is_load    = o.ld;
    in_is_store   = o.st;
    in_funct3     = o.f3;
    in_addr       = o.addr;
    in_store_data = o.sdata;
    in_rd         = o.rd;
    in_rd_we      = o.rd_we;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < MAXC; i++) begin
      exp_stall[i] = 1'b0; exp_wr[i] = 1'b0; chk_a[i] = 1'b0; exp_a[i] = '0;
      exp_dout[i] = '0; exp_we[i] = 1'b0; exp_wa[i] = '0; exp_wd[i] = '0;
    end
  endtask

  // Record what op o, issued in cycle c, implies for later cycles; len is the
  // number of cycles upstream must hold it before the next op may appear.
  task automatic schedule(input op_t o, input int c, output int len);
    int n;
    logic [31:0] ai;
    n = nbytes(o.f3);
    if (!o.valid) begin
      len = 1;
    end else if (o.ld) begin
      for (int k = 0; k <= n; k++) exp_stall[c+k] = 1'b1;
      for (int i = 0; i < n; i++) begin
        chk_a[c+1+i] = 1'b1;
        exp_a[c+1+i] = o.addr + 32'(i);
      end
      if (o.rd_we) begin
        exp_we[c+n+2] = 1'b1;
        exp_wa[c+n+2] = o.rd;
        exp_wd[c+n+2] = load_value(o.addr, o.f3);
      end
      len = n + 2;
    end else if (o.st) begin
      for (int k = 0; k < n; k++) exp_stall[c+k] = 1'b1;
      for (int i = 0; i < n; i++) begin
        ai = o.addr + 32'(i);
        exp_wr[c+1+i]   = 1'b1;
        chk_a[c+1+i]    = 1'b1;
        exp_a[c+1+i]    = ai;
        exp_dout[c+1+i] = o.sdata[8*i +: 8];
        gold_ram[ai[11:0]] = o.sdata[8*i +: 8];
      end
      len = n + 1;
    end else begin
      if (o.rd_we) begin
        exp_we[c+1] = 1'b1;
        exp_wa[c+1] = o.rd;
        exp_wd[c+1] = o.addr;
      end
      len = 1;
    end
  endtask

  task automatic check_cycle(input int c);
    check("stall_req", 32'(stall_req), 32'(exp_stall[c]));
    check("mem_wr", 32'(mem_wr), 32'(exp_wr[c]));
    if (chk_a[c])  check("mem_a", mem_a, exp_a[c]);
    if (exp_wr[c]) check("mem_dout", 32'(mem_dout), 32'(exp_dout[c]));
    if (c > 0) begin
      check("wb_we", 32'(wb_we), 32'(exp_we[c]));
      if (exp_we[c]) begin
        check("wb_addr", 32'(wb_addr), 32'(exp_wa[c]));
        check("wb_data", wb_data, exp_wd[c]);
        wb_log.push_back(wb_data);
      end
    end
  endtask

  // Runs a list of ops back-to-back from an idle stage, checking every cycle.
  task automatic run_ops(input op_t ops[$]);
    int  nxt;
    int  k;
    int  end_c;
    int  len;
    bit  was_last;
    op_t o;
    nxt = 0; k = 0; end_c = 0;
    clear_exp();
    wb_log.delete();
    for (int c = 0; c < MAXC - 8; c++) begin
      @(posedge clk); #1;
      cur_cyc = c;
      if (c == nxt) begin
        if (k < ops.size()) begin
          o = ops[k];
          k++;
          was_last = (k == ops.size());
        end else begin
          o = bubble_op();
          was_last = 1'b0;
        end
        drive_op(o);
        schedule(o, c, len);
        nxt = c + len;
        if (was_last) end_c = nxt;
      end
      @(negedge clk);
      check_cycle(c);
      if (k == ops.size() && c >= end_c) break;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    op_t q[$];
    op_t o;

    for (int i = 0; i < RAM_SZ; i++) gold_ram[i] = init_byte(i);
    rst = 1'b1;
    rdy = 1'b1;
    drive_op(bubble_op());
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wb_we", 32'(wb_we), 32'd0);
    check("reset_mem_wr", 32'(mem_wr), 32'd0);
    check("reset_mem_a", mem_a, 32'd0);
    rst = 1'b0;

    // Halfword store across the top of the address space.
    q.delete();
    q.push_back(mk_op(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'hABCD_1234, 5'd0, 1'b1));
    run_ops(q);

    // Byte 0x80 at 0x100, then sign- and zero-extending byte loads.
    q.delete();
    q.push_back(mk_op(1'b0, 1'b1, 3'b000, 32'h0000_0100, 32'h0000_0080, 5'd0, 1'b0));
    q.push_back(mk_op(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 5'd1, 1'b1));
    q.push_back(mk_op(1'b1, 1'b0, 3'b100, 32'h0000_0100, 32'h0, 5'd2, 1'b1));
    run_ops(q);
    check("lb_sext", wb_log[0], 32'hFFFF_FF80);
    check("lbu_zext", wb_log[1], 32'h0000_0080);

    // Misaligned word: bytes 11,22,33,44 at 0x203..0x206.
    q.delete();
    q.push_back(mk_op(1'b0, 1'b1, 3'b010, 32'h0000_0203, 32'h4433_2211, 5'd0, 1'b0));
    q.push_back(mk_op(1'b1, 1'b0, 3'b010, 32'h0000_0203, 32'h0, 5'd3, 1'b1));
    run_ops(q);
    check("lw_misaligned", wb_log[0], 32'h4433_2211);

    // Store word then load it back with no gap.
    q.delete();
    q.push_back(mk_op(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'h89AB_CDEF, 5'd0, 1'b0));
    q.push_back(mk_op(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd4, 1'b1));
    run_ops(q);
    check("sw_lw_forward", wb_log[0], 32'h89AB_CDEF);

    // LH with rdy low in cycles 2..4: outputs frozen, result 3 cycles late.
    q.delete();
    q.push_back(mk_op(1'b0, 1'b1, 3'b001, 32'h0000_0A10, 32'h0000_F234, 5'd0, 1'b0));
    run_ops(q);
    o = mk_op(1'b1, 1'b0, 3'b001, 32'h0000_0A10, 32'h0, 5'd12, 1'b1);
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive_op(o);
      rdy = !(k >= 2 && k <= 4);
      if (k == 7) in_valid = 1'b0;
      @(negedge clk);
      cur_cyc = k;
      check("frz_stall", 32'(stall_req), (k <= 5) ? 32'd1 : 32'd0);
      check("frz_mem_wr", 32'(mem_wr), 32'd0);
      if (k == 1) check("frz_mem_a", mem_a, 32'h0000_0A10);
      if (k >= 2 && k <= 6) check("frz_mem_a", mem_a, 32'h0000_0A11);
      if (k >= 1) check("frz_wb_we", 32'(wb_we), (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) begin
        check("frz_wb_addr", 32'(wb_addr), 32'd12);
        check("frz_wb_data", wb_data, 32'hFFFF_F234);
      end
    end
    rdy = 1'b1;

    // Reset asserted asynchronously in cycle 3 of a word load.
    o = mk_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd3, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      cur_cyc = k;
      if (k == 0) drive_op(o);
    end
    check("rst_pre_mem_a", mem_a, 32'h0000_0502);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    q.delete();
    q.push_back(mk_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1));
    run_ops(q);
    check("add_after_rst", wb_log[0], 32'h0000_1234);

    // Randomized mix, back-to-back.
    q.delete();
    for (int i = 0; i < 300; i++) q.push_back(rand_op());
    run_ops(q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
